// File: rtl/bit_drain_32.sv
// bit_drain_32: turns a 32-bit event mask into a stream of set-bit indices, one per handshake.
// Define BIT_DRAIN_FLUSH_EN to add a synchronous flush input that abandons a drain in progress.
module bit_drain_32 #(
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
`ifdef BIT_DRAIN_FLUSH_EN
    input  logic        flush,
`endif
    input  logic        in_valid,
    input  logic [31:0] in_data,
    output logic        in_ready,
    output logic        out_valid,
    output logic [4:0]  out_index,
    output logic        out_last,
    input  logic        out_ready,
    output logic [5:0]  remaining,
    output logic        empty_pulse
);

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t      r_state;
    logic [31:0] r_shadow;
    logic        r_emptyPulse;

    logic [4:0]  w_index;
    logic [5:0]  w_count;
    logic [31:0] w_oneHot;

    // The loop direction makes the last match win, so scanning opposite to the
    // emit order leaves the wanted bit in w_index.
    always_comb begin
        w_index = 5'd0;
        if (LSB_FIRST) begin
            for (int i = 31; i >= 0; i--) begin
                if (r_shadow[i]) w_index = 5'(i);
            end
        end else begin
            for (int i = 0; i < 32; i++) begin
                if (r_shadow[i]) w_index = 5'(i);
            end
        end
    end

    always_comb begin
        w_count = 6'd0;
        for (int i = 0; i < 32; i++) begin
            w_count = w_count + 6'(r_shadow[i]);
        end
    end

    assign w_oneHot    = 32'd1 << w_index;
    assign in_ready    = (r_state == IDLE);
    assign out_valid   = (r_state == DRAIN);
    assign out_index   = (r_state == DRAIN) ? w_index : 5'd0;
    assign remaining   = (r_state == DRAIN) ? w_count : 6'd0;
    assign out_last    = (r_state == DRAIN) && (w_count == 6'd1);
    assign empty_pulse = r_emptyPulse;

    // A zero mask is acknowledged with a one-cycle pulse instead of entering DRAIN.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_shadow     <= 32'd0;
            r_emptyPulse <= 1'b0;
        end else begin
            r_emptyPulse <= 1'b0;
`ifdef BIT_DRAIN_FLUSH_EN
            if (flush) begin
                r_state  <= IDLE;
                r_shadow <= 32'd0;
            end else
`endif
            begin
                case (r_state)
                    IDLE: begin
                        if (in_valid) begin
                            if (in_data != 32'd0) begin
                                r_shadow <= in_data;
                                r_state  <= DRAIN;
                            end else begin
                                r_emptyPulse <= 1'b1;
                            end
                        end
                    end
                    DRAIN: begin
                        if (out_ready) begin
                            r_shadow <= r_shadow & ~w_oneHot;
                            if (w_count == 6'd1) r_state <= IDLE;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bit_drain_32.sv
// Directed bench for bit_drain_32: LSB-first and MSB-first instances share stimulus,
// each checked against its own queue of expected indices built from the loaded mask.
module tb_bit_drain_32;

    typedef struct {
        logic [4:0] idx;
        logic       last;
        logic [5:0] rem;
    } exp_t;

    logic        clock;
    logic        reset;
    logic        flush;
    logic        inValid;
    logic [31:0] inData;
    logic        outReady;

    logic        inReadyL, outValidL, outLastL, emptyPulseL;
    logic [4:0]  outIndexL;
    logic [5:0]  remainingL;
    logic        inReadyM, outValidM, outLastM, emptyPulseM;
    logic [4:0]  outIndexM;
    logic [5:0]  remainingM;

    exp_t expL[$];
    exp_t expM[$];
    int   errors = 0;
    int   checks = 0;
    int   transfers;

    bit_drain_32 #(.LSB_FIRST(1'b1)) dutLsb (
        .clock(clock), .reset(reset),
`ifdef BIT_DRAIN_FLUSH_EN
        .flush(flush),
`endif
        .in_valid(inValid), .in_data(inData), .in_ready(inReadyL),
        .out_valid(outValidL), .out_index(outIndexL), .out_last(outLastL),
        .out_ready(outReady), .remaining(remainingL), .empty_pulse(emptyPulseL)
    );

    bit_drain_32 #(.LSB_FIRST(1'b0)) dutMsb (
        .clock(clock), .reset(reset),
`ifdef BIT_DRAIN_FLUSH_EN
        .flush(flush),
`endif
        .in_valid(inValid), .in_data(inData), .in_ready(inReadyM),
        .out_valid(outValidM), .out_index(outIndexM), .out_last(outLastM),
        .out_ready(outReady), .remaining(remainingM), .empty_pulse(emptyPulseM)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Drives one load edge and queues the index sequence each instance should produce.
    task automatic applyStimulus(input logic [31:0] mask);
        int rem;
        rem = $countones(mask);
        for (int k = 0; k < 32; k++) begin
            if (mask[k]) begin
                expL.push_back('{idx: 5'(k), last: (rem == 1), rem: 6'(rem)});
                rem--;
            end
        end
        rem = $countones(mask);
        for (int k = 31; k >= 0; k--) begin
            if (mask[k]) begin
                expM.push_back('{idx: 5'(k), last: (rem == 1), rem: 6'(rem)});
                rem--;
            end
        end
        inValid = 1'b1;
        inData  = mask;
        step();
        inValid = 1'b0;
        inData  = $urandom();
    endtask

    task automatic checkHead(input string tag);
        checkOutput({tag, ".validL"}, 32'(outValidL), 32'd1);
        checkOutput({tag, ".validM"}, 32'(outValidM), 32'd1);
        checkOutput({tag, ".inReadyL"}, 32'(inReadyL), 32'd0);
        checkOutput({tag, ".idxL"}, 32'(outIndexL), 32'(expL[0].idx));
        checkOutput({tag, ".lastL"}, 32'(outLastL), 32'(expL[0].last));
        checkOutput({tag, ".remL"}, 32'(remainingL), 32'(expL[0].rem));
        checkOutput({tag, ".idxM"}, 32'(outIndexM), 32'(expM[0].idx));
        checkOutput({tag, ".lastM"}, 32'(outLastM), 32'(expM[0].last));
        checkOutput({tag, ".remM"}, 32'(remainingM), 32'(expM[0].rem));
    endtask

    // Drains until the scoreboard is empty; a stall cycle re-checks the same head, proving hold.
    task automatic drainExpect(input string tag, input bit toggle);
        int  cycles;
        bit  phase;
        cycles    = 0;
        phase     = 1'b1;
        transfers = 0;
        while (expL.size() > 0 && expM.size() > 0 && cycles < 200) begin
            outReady = toggle ? phase : 1'b1;
            phase    = ~phase;
            checkHead(tag);
            if (outReady) begin
                void'(expL.pop_front());
                void'(expM.pop_front());
                transfers++;
            end
            step();
            cycles++;
        end
        if (expL.size() != 0 || expM.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s.timeout observed=%0d expected=0 entries left", tag, expL.size());
            expL.delete();
            expM.delete();
        end
        outReady = 1'b0;
        checkOutput({tag, ".doneReadyL"}, 32'(inReadyL), 32'd1);
        checkOutput({tag, ".doneReadyM"}, 32'(inReadyM), 32'd1);
        checkOutput({tag, ".doneValidL"}, 32'(outValidL), 32'd0);
        checkOutput({tag, ".doneValidM"}, 32'(outValidM), 32'd0);
    endtask

    initial begin
        reset    = 1'b1;
        flush    = 1'b0;
        inValid  = 1'b1;
        inData   = 32'h0000_00F0;
        outReady = 1'b0;
        step();
        checkOutput("rst.inReady", 32'(inReadyL), 32'd1);
        checkOutput("rst.outValid", 32'(outValidL), 32'd0);
        checkOutput("rst.remaining", 32'(remainingL), 32'd0);
        checkOutput("rst.outIndex", 32'(outIndexL), 32'd0);
        checkOutput("rst.outLast", 32'(outLastL), 32'd0);
        checkOutput("rst.emptyPulse", 32'(emptyPulseL), 32'd0);
        inValid = 1'b0;
        reset   = 1'b0;
        step();
        checkOutput("rst.noCapture", 32'(outValidL), 32'd0);

        $display("[TB] mask 8000_0011, ready held high");
        applyStimulus(32'h8000_0011);
        drainExpect("m8011", 1'b0);
        checkOutput("m8011.transfers", 32'(transfers), 32'd3);

        $display("[TB] mask FFFF_FFFF, ready toggling");
        applyStimulus(32'hFFFF_FFFF);
        drainExpect("mAll", 1'b1);
        checkOutput("mAll.transfers", 32'(transfers), 32'd32);

        $display("[TB] zero mask");
        applyStimulus(32'h0);
        checkOutput("zero.pulseL", 32'(emptyPulseL), 32'd1);
        checkOutput("zero.pulseM", 32'(emptyPulseM), 32'd1);
        checkOutput("zero.valid", 32'(outValidL), 32'd0);
        checkOutput("zero.inReady", 32'(inReadyL), 32'd1);
        step();
        checkOutput("zero.pulseGone", 32'(emptyPulseL), 32'd0);
        checkOutput("zero.validStill", 32'(outValidL), 32'd0);
        checkOutput("zero.inReadyStill", 32'(inReadyL), 32'd1);

        $display("[TB] mask 0000_0F00 with reset mid-drain");
        applyStimulus(32'h0000_0F00);
        outReady = 1'b1;
        for (int n = 0; n < 2; n++) begin
            checkHead("rstMid");
            void'(expL.pop_front());
            void'(expM.pop_front());
            step();
        end
        checkOutput("rstMid.preIdx", 32'(outIndexL), 32'd10);
        reset = 1'b1;
        #2;
        checkOutput("rstMid.validL", 32'(outValidL), 32'd0);
        checkOutput("rstMid.validM", 32'(outValidM), 32'd0);
        checkOutput("rstMid.remaining", 32'(remainingL), 32'd0);
        checkOutput("rstMid.inReady", 32'(inReadyL), 32'd1);
        expL.delete();
        expM.delete();
        #2;
        reset    = 1'b0;
        outReady = 1'b0;
        step();
        applyStimulus(32'h0000_0001);
        drainExpect("one", 1'b0);
        checkOutput("one.transfers", 32'(transfers), 32'd1);

`ifdef BIT_DRAIN_FLUSH_EN
        $display("[TB] mask 0000_00FF with flush on third transfer");
        applyStimulus(32'h0000_00FF);
        outReady = 1'b1;
        for (int n = 0; n < 2; n++) begin
            checkHead("flush");
            void'(expL.pop_front());
            void'(expM.pop_front());
            step();
        end
        checkOutput("flush.preIdx", 32'(outIndexL), 32'd2);
        flush = 1'b1;
        step();
        flush    = 1'b0;
        outReady = 1'b0;
        expL.delete();
        expM.delete();
        checkOutput("flush.inReady", 32'(inReadyL), 32'd1);
        checkOutput("flush.valid", 32'(outValidL), 32'd0);
        checkOutput("flush.noPulse", 32'(emptyPulseL), 32'd0);
        step();
        checkOutput("flush.stayIdle", 32'(outValidL), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bit_drain_32.md
# bit_drain_32

Serial set-bit extractor for 32-bit masks. It is the unpacking counterpart to the bitwise-OR path: event and status sources are OR-combined into one 32-bit mask, and this block turns that mask back into a stream of individual bit indices, one per handshake. It sits between the processor's pending-event register and the unlock-sequence controller. The controller consumes one event index at a time and applies backpressure.

## Interface
Parameters:
- LSB_FIRST, default 1. 1 emits indices from lowest to highest; 0 emits from highest to lowest.

Ports:
- clock, input, 1: single clock, rising edge.
- reset, input, 1: asynchronous, active-high.
- in_valid, input, 1: a mask is offered on in_data.
- in_data, input, 32: mask to drain.
- in_ready, output, 1: block can accept a mask.
- out_valid, output, 1: out_index holds a valid index.
- out_index, output, 5: position of the current set bit.
- out_last, output, 1: current index is the final set bit of the mask.
- out_ready, input, 1: consumer accepts the current index.
- remaining, output, 6: set bits still to be emitted, including the current one.
- empty_pulse, output, 1: one-cycle pulse when an all-zero mask is accepted.

## Operation
- Registers: state (IDLE or DRAIN), and a 32-bit shadow mask.
- Reset values:
  - state is IDLE and shadow is 0.
  - out_valid, out_index, out_last, remaining and empty_pulse are all 0.
  - in_ready is 1 (it is decoded from IDLE), but no capture occurs while reset is high.
- IDLE:
  - in_ready = 1 and out_valid = 0.
  - A load occurs when in_valid and in_ready are both high at a clock edge.
  - Nonzero mask: shadow <= in_data and state <= DRAIN.
  - Zero mask: shadow stays 0, state stays IDLE, and empty_pulse = 1 for the next cycle only.
- DRAIN:
  - in_ready = 0 and out_valid = 1.
  - out_index is the lowest set bit of shadow (LSB_FIRST=1) or the highest set bit (LSB_FIRST=0).
  - remaining = popcount(shadow).
  - out_last = 1 exactly when remaining == 1.
- Transfer: out_valid and out_ready both high at an edge.
  - The emitted bit is cleared in shadow.
  - If out_last was 1, state <= IDLE.
- Stall: with out_ready low, out_index, out_last and remaining hold stable indefinitely.
- Every emitted index is unique. For one mask, exactly popcount(in_data) transfers occur, in strict monotonic order.
- in_data is sampled only at the load edge. Later changes to in_data do not affect the drain.
- Reset mid-drain: the block returns to IDLE immediately (asynchronous), the shadow is discarded, and out_valid drops without a clock edge.

## Timing
- Load edge N: out_valid is high from cycle N+1. This is the load-to-first-index latency of 1 cycle.
- Throughput: one index per cycle while out_ready is held high.
- A 32-bit all-ones mask drains in 32 consecutive cycles.
- Final transfer at edge M: in_ready = 1 in cycle M+1. There is no same-edge reload. A full mask costs popcount + 1 cycles.
- out_index, out_last and remaining are combinational from the shadow register and state. They carry no added latency.
- empty_pulse is registered: it is high in the cycle after the zero-mask load edge.

## Configuration
- BIT_DRAIN_FLUSH_EN defined:
  - Adds an input port flush (1 bit, synchronous, active-high).
  - flush high at an edge forces state <= IDLE and shadow <= 0, overriding a coincident transfer.
  - flush in IDLE overrides a coincident load: the mask is not captured.
  - empty_pulse is not asserted on a flush.
- BIT_DRAIN_FLUSH_EN undefined:
  - The flush port is absent.
  - A drain can be abandoned only via reset.

## Test plan
- Mask 0x8000_0011, LSB_FIRST=1, out_ready held high -> indices 0, 4, 31 on three consecutive cycles. remaining reads 3, 2, 1. out_last is high only with index 31. in_ready is high the cycle after.
- Same mask with LSB_FIRST=0 -> indices 31, 4, 0. out_last is high with index 0.
- Mask 0xFFFF_FFFF, out_ready toggled 1,0,1,0... -> 32 indices 0..31, each held stable through its stall cycle. Exactly 32 transfers. remaining reaches 1 at index 31.
- Mask 0x0000_0000 loaded -> empty_pulse high for exactly one cycle, out_valid never asserts, in_ready stays 1.
- Mask 0x0000_0F00, reset asserted mid-cycle after index 9 is emitted -> out_valid drops asynchronously and remaining = 0. A new mask 0x1 then yields index 0 with out_last = 1.
- With BIT_DRAIN_FLUSH_EN: mask 0x0000_00FF, flush at the third transfer edge -> indices 0 and 1 emitted, then IDLE and in_ready = 1. Index 2 is not reissued.
